// File: rtl/mod_op_pkg.sv
// -----------------------------------------------------------------------------
// mod_op_pkg
// Shared definitions for the modular-arithmetic command issuer:
//   - op_e    : operation encodings seen on cmd_op_i / op_sel_o
//   - state_e : issuer FSM state encoding
//   - DATA_W  : operand / result width
//   - P256    : SM2 prime, used by benches to build reference results
// -----------------------------------------------------------------------------
package mod_op_pkg;

    localparam int unsigned DATA_W = 256;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,   // 512-bit reduction of {a,b}
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_RSV = 2'b11    // reserved: answered with an error, never issued
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    localparam logic [DATA_W-1:0] P256 =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

endpackage

// File: rtl/mod_cmd_fifo.sv
// -----------------------------------------------------------------------------
// mod_cmd_fifo
// Command buffer in front of the issuer FSM. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push, i_data write one entry (caller gates with o_rdy)
//   i_pop          drop the head entry (caller gates with o_head_vld)
//   o_data         head entry
//   o_rdy          registered "not full"; low in reset
//   o_head_vld     registered "not empty", one cycle behind the pointers
//   o_nempty       immediate "not empty" from the pointers
// -----------------------------------------------------------------------------
module mod_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_rdy,
    output logic             o_head_vld,
    output logic             o_nempty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_rdy;
    logic             r_head_vld;

    logic [AW:0]      w_wr_nxt;
    logic [AW:0]      w_rd_nxt;
    logic             w_full_nxt;

    assign w_wr_nxt   = r_wr_ptr + (AW+1)'(i_push);
    assign w_rd_nxt   = r_rd_ptr + (AW+1)'(i_pop);
    assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                        (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rdy      <= 1'b0;
            r_head_vld <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_rdy      <= ~w_full_nxt;
            // Head-valid looks at the current pointers, so it trails a push by
            // one cycle. The consumer pops at most once per command and spends
            // at least one cycle away from IDLE afterwards, so the stale value
            // right after a pop is never acted on.
            r_head_vld <= (r_wr_ptr != r_rd_ptr);
        end
    end

    // NOTE: storage has no reset; entries are only read after being written,
    // and leaving them out of reset keeps wide data off the reset tree.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
    assign o_rdy      = r_rdy;
    assign o_head_vld = r_head_vld;
    assign o_nempty   = (r_wr_ptr != r_rd_ptr);

endmodule

// File: rtl/mod_op_issuer.sv
// -----------------------------------------------------------------------------
// mod_op_issuer
// Initiator side of the mod-unit handshake. Tagged MUL/ADD/SUB commands are
// buffered in mod_cmd_fifo, issued one at a time (request and operands held
// until mod_fin_i) and answered in order on a valid/ready response port.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_vld_i/cmd_rdy_o              command handshake (ready = FIFO not full)
//   cmd_op_i, cmd_tag_i, cmd_a_i/b_i command fields
//   mod_vld_o, op_sel_o, p512_a_o    request to mod unit, p512_a_o = {a,b}
//   mod_fin_i                        completion pulse from mod unit
//   add_sub_res_i, mul_res_i         mod-unit results
//   rsp_vld_o/rsp_rdy_i              response handshake
//   rsp_tag_o, rsp_res_o, rsp_err_o  response fields
//   busy_o                           FIFO non-empty or FSM not IDLE
//
// Build option: MOD_ISSUE_TIMEOUT_EN adds a watchdog that abandons a request
// after TIMEOUT_CYC ISSUE cycles and answers it with an error.
// -----------------------------------------------------------------------------
module mod_op_issuer
    import mod_op_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_vld_i,
    output logic                cmd_rdy_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [TAG_W-1:0]    cmd_tag_i,
    input  logic [DATA_W-1:0]   cmd_a_i,
    input  logic [DATA_W-1:0]   cmd_b_i,
    output logic                mod_vld_o,
    output logic [1:0]          op_sel_o,
    output logic [2*DATA_W-1:0] p512_a_o,
    input  logic                mod_fin_i,
    input  logic [DATA_W-1:0]   add_sub_res_i,
    input  logic [DATA_W-1:0]   mul_res_i,
    output logic                rsp_vld_o,
    input  logic                rsp_rdy_i,
    output logic [TAG_W-1:0]    rsp_tag_o,
    output logic [DATA_W-1:0]   rsp_res_o,
    output logic                rsp_err_o,
    output logic                busy_o
);

    localparam int ENTRY_W = 2 + TAG_W + 2*DATA_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mod_op_issuer: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mod_op_issuer: TIMEOUT_CYC must be >= 1");
    end

    // ---------------------------------------------------------------- FIFO
    logic               w_push;
    logic               w_pop;
    logic               w_cmd_rdy;
    logic               w_head_vld;
    logic               w_fifo_nempty;
    logic [ENTRY_W-1:0] w_head;
    op_e                w_head_op;

    assign w_push    = cmd_vld_i & w_cmd_rdy;
    assign w_head_op = op_e'(w_head[ENTRY_W-1 -: 2]);

    mod_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_data     ({cmd_op_i, cmd_tag_i, cmd_a_i, cmd_b_i}),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_rdy      (w_cmd_rdy),
        .o_head_vld (w_head_vld),
        .o_nempty   (w_fifo_nempty)
    );

    // ------------------------------------------------------ working registers
    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 r_op;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_res;
    logic                r_err;
    logic                w_capture;

`ifdef MOD_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

    // mod_fin_i in the limit cycle takes priority over the watchdog.
    assign w_timeout = (r_state == ST_ISSUE) && !mod_fin_i &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_head_vld) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_head_op == OP_RSV) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mod_fin_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
`ifdef MOD_ISSUE_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_rdy_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The result is cleared on pop, so reserved ops and timeouts answer 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= OP_MUL;
            r_tag <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else if (w_pop) begin
            r_op  <= w_head_op;
            r_tag <= w_head[2*DATA_W +: TAG_W];
            r_a   <= w_head[DATA_W +: DATA_W];
            r_b   <= w_head[0 +: DATA_W];
            r_res <= '0;
            r_err <= (w_head_op == OP_RSV);
        end else if (w_capture) begin
            r_res <= (r_op == OP_MUL) ? mul_res_i : add_sub_res_i;
        end
`ifdef MOD_ISSUE_TIMEOUT_EN
        else if (w_timeout) begin
            r_res <= '0;
            r_err <= 1'b1;
        end
`endif
    end

    // ---------------------------------------------------------------- outputs
    assign cmd_rdy_o = w_cmd_rdy;
    assign mod_vld_o = (r_state == ST_ISSUE);
    assign op_sel_o  = r_op;
    assign p512_a_o  = {r_a, r_b};
    assign rsp_vld_o = (r_state == ST_RESP);
    assign rsp_tag_o = r_tag;
    assign rsp_res_o = r_res;
    assign rsp_err_o = r_err;
    assign busy_o    = w_fifo_nempty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_mod_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_mod_op_issuer
// Scoreboard bench for mod_op_issuer. Accepted commands push their expected
// mod-unit request and expected response into queues; independent monitors
// pop and compare when the DUT raises mod_vld_o or completes a response.
// A stub mod unit answers requests after a programmable delay, driving a
// decoy value on the result bus that must not be selected.
// Build with MOD_ISSUE_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYC=16).
// -----------------------------------------------------------------------------
module tb_mod_op_issuer;
    import mod_op_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
`ifdef MOD_ISSUE_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1023;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_vld_i;
    logic               cmd_rdy_o;
    logic [1:0]         cmd_op_i;
    logic [TAG_W-1:0]   cmd_tag_i;
    logic [255:0]       cmd_a_i;
    logic [255:0]       cmd_b_i;
    logic               mod_vld_o;
    logic [1:0]         op_sel_o;
    logic [511:0]       p512_a_o;
    logic               mod_fin_i = 1'b0;
    logic [255:0]       add_sub_res_i = '0;
    logic [255:0]       mul_res_i = '0;
    logic               rsp_vld_o;
    logic               rsp_rdy_i = 1'b0;
    logic [TAG_W-1:0]   rsp_tag_o;
    logic [255:0]       rsp_res_o;
    logic               rsp_err_o;
    logic               busy_o;

    mod_op_issuer #(
        .DEPTH       (DEPTH),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_vld_i     (cmd_vld_i),
        .cmd_rdy_o     (cmd_rdy_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_tag_i     (cmd_tag_i),
        .cmd_a_i       (cmd_a_i),
        .cmd_b_i       (cmd_b_i),
        .mod_vld_o     (mod_vld_o),
        .op_sel_o      (op_sel_o),
        .p512_a_o      (p512_a_o),
        .mod_fin_i     (mod_fin_i),
        .add_sub_res_i (add_sub_res_i),
        .mul_res_i     (mul_res_i),
        .rsp_vld_o     (rsp_vld_o),
        .rsp_rdy_i     (rsp_rdy_i),
        .rsp_tag_o     (rsp_tag_o),
        .rsp_res_o     (rsp_res_o),
        .rsp_err_o     (rsp_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [255:0]     res;
        logic             err;
    } rsp_t;

    typedef struct {
        logic [1:0]   op;
        logic [511:0] p512;
    } req_t;

    rsp_t exp_rsp_q[$];
    req_t exp_req_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Reference arithmetic over the SM2 prime field.
    function automatic logic [255:0] ref_result(input logic [1:0] op, input logic [255:0] a,
                                                input logic [255:0] b);
        logic [512:0] p, wa, wb, r;
        p  = {257'd0, P256};
        wa = {257'd0, a} % p;
        wb = {257'd0, b} % p;
        case (op)
            2'b00:   r = {1'b0, a, b} % p;
            2'b01:   r = (wa + wb) % p;
            2'b10:   r = (wa + p - wb) % p;
            default: r = '0;
        endcase
        return r[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_push(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                              input logic [255:0] a, input logic [255:0] b, input bit exp_to);
        rsp_t r;
        req_t q;
        r.tag = tag;
        r.err = (op == 2'b11) || exp_to;
        r.res = r.err ? 256'd0 : ref_result(op, a, b);
        exp_rsp_q.push_back(r);
        if (op != 2'b11) begin
            q.op   = op;
            q.p512 = {a, b};
            exp_req_q.push_back(q);
        end
    endtask

    // -------------------------------------------------------------- stub unit
    bit stub_en    = 1'b1;
    bit stub_force = 1'b0;
    int fin_delay  = 3;
    int stub_cnt   = 0;

    always @(posedge clk) begin
        #1;
        mod_fin_i     = 1'b0;
        add_sub_res_i = '0;
        mul_res_i     = '0;
        if (stub_force) begin
            mod_fin_i = 1'b1;
        end else if (mod_vld_o && stub_en) begin
            if (stub_cnt >= fin_delay) begin
                mod_fin_i = 1'b1;
                stub_cnt  = 0;
                if (op_sel_o == 2'b00) begin
                    mul_res_i     = ref_result(2'b00, p512_a_o[511:256], p512_a_o[255:0]);
                    add_sub_res_i = 256'hDEAD;
                end else begin
                    add_sub_res_i = ref_result(op_sel_o, p512_a_o[511:256], p512_a_o[255:0]);
                    mul_res_i     = 256'hBEEF;
                end
            end else begin
                stub_cnt++;
            end
        end else begin
            stub_cnt = 0;
        end
    end

    // rdy_mode: 0 = hold low, 1 = hold high, 2 = random
    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_rdy_i = 1'b0;
            1:       rsp_rdy_i = 1'b1;
            default: rsp_rdy_i = 1'($urandom_range(0, 1));
        endcase
    end

    // ------------------------------------------------------ request monitor
    bit   prev_vld = 1'b0;
    bit   seen_req = 1'b0;
    bit   fin_seen = 1'b0;
    int   gap      = 0;
    req_t held;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
            seen_req = 1'b0;
            fin_seen = 1'b0;
            gap      = 0;
        end else begin
            if (fin_seen) begin
                check("fin_drops_mod_vld", mod_vld_o, 1'b0);
                check("fin_raises_rsp_vld", rsp_vld_o, 1'b1);
                fin_seen = 1'b0;
            end
            if (mod_vld_o && !prev_vld) begin
                if (seen_req) check("req_gap_ge2", gap >= 2, 1'b1);
                if (exp_req_q.size() == 0) begin
                    fail_event("unexpected_mod_request");
                end else begin
                    held = exp_req_q.pop_front();
                    check("req_op_sel", op_sel_o, held.op);
                    check("req_p512", p512_a_o, held.p512);
                end
                seen_req = 1'b1;
            end else if (mod_vld_o) begin
                check("req_op_sel_hold", op_sel_o, held.op);
                check("req_p512_hold", p512_a_o, held.p512);
            end
            if (mod_vld_o) gap = 0;
            else           gap++;
            if (mod_vld_o && mod_fin_i) fin_seen = 1'b1;
            prev_vld = mod_vld_o;
        end
    end

    // ----------------------------------------------------- response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_vld_o && rsp_rdy_i) begin
            if (exp_rsp_q.size() == 0) begin
                fail_event("unexpected_response");
            end else begin
                e = exp_rsp_q.pop_front();
                check("rsp_tag", rsp_tag_o, e.tag);
                check("rsp_res", rsp_res_o, e.res);
                check("rsp_err", rsp_err_o, e.err);
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic send(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [255:0] a, input logic [255:0] b, input bit exp_to);
        cmd_vld_i = 1'b1;
        cmd_op_i  = op;
        cmd_tag_i = tag;
        cmd_a_i   = a;
        cmd_b_i   = b;
        for (int i = 0; i < 500; i++) begin
            if (cmd_rdy_o) begin
                model_push(op, tag, a, b, exp_to);
                @(posedge clk); #1;
                cmd_vld_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("cmd_accept_timeout", cmd_rdy_o, 1'b1);
        cmd_vld_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((exp_rsp_q.size() != 0 || busy_o) && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        check({name, "_drained"}, exp_rsp_q.size() == 0 && !busy_o, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------ main
    initial begin
        logic [1:0]   bp_op [6];
        logic [255:0] bp_a  [6];
        logic [255:0] bp_b  [6];
        int acc, c, act;

        rst_n     = 1'b0;
        cmd_vld_i = 1'b0;
        cmd_op_i  = '0;
        cmd_tag_i = '0;
        cmd_a_i   = '0;
        cmd_b_i   = '0;

        // Reset state.
        repeat (3) @(posedge clk); #1;
        check("rst_cmd_rdy", cmd_rdy_o, 1'b0);
        check("rst_mod_vld", mod_vld_o, 1'b0);
        check("rst_rsp_vld", rsp_vld_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rsp_fields", {rsp_tag_o, rsp_res_o, rsp_err_o}, '0);
        check("rst_req_fields", {op_sel_o, p512_a_o}, '0);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", cmd_rdy_o, 1'b0);
        @(posedge clk); #1;
        check("rdy_after_edge", cmd_rdy_o, 1'b1);

        // ADD tag 3: latency from push to request.
        fin_delay = 3;
        send(2'b01, 4'd3, P256 - 256'd1, 256'd2, 1'b0);
        check("lat_edge_k", mod_vld_o, 1'b0);
        @(posedge clk); #1;
        check("lat_edge_k1", mod_vld_o, 1'b0);
        @(posedge clk); #1;
        check("lat_edge_k2", mod_vld_o, 1'b1);
        check("lat_busy", busy_o, 1'b1);
        drain("add");

        // MUL with decoy on add_sub_res_i.
        send(2'b00, 4'd5, 256'd0, P256 + 256'd5, 1'b0);
        drain("mul");

        // Backpressure: 6 offered, 5 fit (working regs + FIFO).
        rdy_mode  = 0;
        fin_delay = 1;
        for (int i = 0; i < 6; i++) begin
            bp_op[i] = 2'($urandom_range(0, 2));
            bp_a[i]  = rand256();
            bp_b[i]  = rand256();
        end
        acc = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cmd_vld_i = (acc < 6);
            if (acc < 6) begin
                cmd_op_i  = bp_op[acc];
                cmd_tag_i = TAG_W'(acc);
                cmd_a_i   = bp_a[acc];
                cmd_b_i   = bp_b[acc];
            end
            if (cmd_vld_i && cmd_rdy_o) begin
                model_push(bp_op[acc], TAG_W'(acc), bp_a[acc], bp_b[acc], 1'b0);
                acc++;
            end
            @(posedge clk); #1;
        end
        cmd_vld_i = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_cmd_rdy_low", cmd_rdy_o, 1'b0);
        rdy_mode = 1;
        drain("backpressure");

        // Reserved op.
        send(2'b11, 4'd7, rand256(), rand256(), 1'b0);
        drain("reserved");

        // Randomized traffic.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            fin_delay = $urandom_range(0, 4);
            send(($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                 TAG_W'($urandom), rand256(), rand256(), 1'b0);
        end
        rdy_mode = 1;
        drain("random");

        // Reset in the middle of ISSUE with two commands queued.
        fin_delay = 1000;
        send(2'b01, 4'd1, rand256(), rand256(), 1'b0);
        send(2'b10, 4'd2, rand256(), rand256(), 1'b0);
        send(2'b00, 4'd3, rand256(), rand256(), 1'b0);
        c = 0;
        while (!mod_vld_o && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("rst_issue_started", mod_vld_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_mod_vld", mod_vld_o, 1'b0);
        check("midrst_rsp_vld", rsp_vld_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        exp_rsp_q.delete();
        exp_req_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        stub_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stub_force = 1'b0;
        act = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mod_vld_o || rsp_vld_o || busy_o) act++;
        end
        check("postrst_quiet_cycles", act, 0);
        fin_delay = 2;
        send(2'b10, 4'd4, rand256(), rand256(), 1'b0);
        drain("after_reset");

`ifdef MOD_ISSUE_TIMEOUT_EN
        // Watchdog: first request abandoned after TO_CYC cycles, second normal.
        stub_en = 1'b0;
        send(2'b01, 4'd9, rand256(), rand256(), 1'b1);
        send(2'b10, 4'd10, rand256(), rand256(), 1'b0);
        c = 0;
        while (!mod_vld_o && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        act = 0;
        while (mod_vld_o && act < 100) begin
            act++;
            @(posedge clk); #1;
        end
        stub_en = 1'b1;
        check("timeout_issue_cycles", act, TO_CYC);
        drain("timeout");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_op_issuer.md
Name: mod_op_issuer

Overview:
- Initiator side of the modular-arithmetic handshake (mod_vld / op_sel / p512 operand in; mod_fin / results back).
- Accepts tagged MUL-reduce / ADD / SUB commands from the point-arithmetic controller and buffers them in a small FIFO.
- Issues one command at a time to the mod unit, holding request and operands stable until completion.
- Returns results in order over a valid/ready response port.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TAG_W, 4, command tag width
- TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_vld_i  in  1  command valid
- cmd_rdy_o  out  1  command ready (FIFO not full)
- cmd_op_i  in  2  00 MUL(reduce 512b), 01 ADD, 10 SUB, 11 reserved
- cmd_tag_i  in  TAG_W  command tag
- cmd_a_i  in  256  operand a
- cmd_b_i  in  256  operand b
- mod_vld_o  out  1  request to mod unit
- op_sel_o  out  2  operation select to mod unit
- p512_a_o  out  512  {a,b}
- mod_fin_i  in  1  completion pulse from mod unit
- add_sub_res_i  in  256  ADD/SUB result
- mul_res_i  in  256  reduction result
- rsp_vld_o  out  1  response valid
- rsp_rdy_i  in  1  response ready
- rsp_tag_o  out  TAG_W  echoed tag
- rsp_res_o  out  256  result
- rsp_err_o  out  1  error (reserved op / timeout)
- busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values: every output 0; cmd_rdy_o 0 while in reset and 1 from the first edge after reset release. FIFO empty, FSM in IDLE.
- FIFO:
  - Push on cmd_vld_i & cmd_rdy_o; cmd_rdy_o = ~full, registered.
  - Simultaneous push and pop are legal when the FIFO is neither full nor empty.
  - Pointers wrap modulo DEPTH, with an extra wrap bit for full/empty discrimination.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE, FIFO non-empty: pop the head into working registers (op, tag, a, b).
    - op==11: go to RESP with rsp_err_o=1 and rsp_res_o=0. No mod_vld_o pulse.
    - Otherwise: go to ISSUE and assert mod_vld_o at the same edge.
  - ISSUE: mod_vld_o, op_sel_o and p512_a_o are held stable.
    - On mod_fin_i=1, capture the result: mul_res_i if op==00, else add_sub_res_i.
    - At that same edge, drop mod_vld_o and go to RESP.
  - RESP: rsp_vld_o=1, with rsp_tag_o, rsp_res_o and rsp_err_o stable until rsp_rdy_i.
    - On handshake, clear rsp_vld_o and go to IDLE.
- Latency:
  - A command pushed into an empty FIFO at edge k gives mod_vld_o high after edge k+2.
  - mod_fin_i sampled at edge t gives mod_vld_o low and rsp_vld_o high after edge t.
- Protocol guarantees:
  - mod_vld_o is low for at least 2 cycles between consecutive requests (RESP + IDLE).
  - mod_fin_i outside ISSUE is ignored.
  - Responses are returned in command order.
- Reset mid-operation: all state is cleared asynchronously and mod_vld_o drops immediately. Queued commands are discarded. A late mod_fin_i after reset release is ignored (FSM is in IDLE).

Optional Feature:
- Macro MOD_ISSUE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYC without mod_fin_i: drop mod_vld_o, go to RESP with rsp_err_o=1 and rsp_res_o=0.
  - If mod_fin_i arrives in the same cycle as the limit, mod_fin_i wins.
- Undefined: no counter; ISSUE waits indefinitely; rsp_err_o is set only for op 11.

Decomposition:
- Package mod_op_pkg:
  - OP_MUL/OP_ADD/OP_SUB/OP_RSV encodings
  - FSM state encoding
  - P256 constant (SM2 prime, for benches)
- Sub-module mod_cmd_fifo (DEPTH×(2+TAG_W+512) registers, full/empty flags).
- FSM and result capture stay in the top.

Test Plan:
- ADD, tag 3, a=P256-1, b=2; stub fires mod_fin_i 3 cycles after mod_vld_o with add_sub_res_i=1:
  - op_sel_o=01 and p512_a_o={a,b} stable through ISSUE.
  - rsp_res=1, rsp_tag=3, err=0.
- MUL, a=0, b=P256+5; stub drives mul_res_i=5 and add_sub_res_i=0xDEAD:
  - rsp_res=5, proving the result mux selects on op.
- rsp_rdy_i held low; 6 commands offered back-to-back; stub returns fin after 1 cycle:
  - Exactly 5 are accepted (1 in working regs + 4 in FIFO), then cmd_rdy_o=0.
  - Releasing rsp_rdy_i returns tags 0..4 in order.
  - mod_vld_o is low ≥2 cycles between requests.
- op=11, tag 7: no mod_vld_o pulse; rsp_err=1, rsp_res=0, rsp_tag=7.
- rst_n pulsed low 2 cycles into ISSUE with 2 commands queued:
  - mod_vld_o, rsp_vld_o and busy_o go low immediately.
  - A stub mod_fin_i after release is ignored and no response appears.
- MOD_ISSUE_TIMEOUT_EN with TIMEOUT_CYC=16, stub never fires:
  - mod_vld_o falls after 16 ISSUE cycles; rsp_err=1, rsp_res=0.
  - The next queued command then issues normally.
